iob_cpu_bus_bridge: RTL and testbench
=====================================

Name: iob_cpu_bus_bridge

Overview:
Parametrised bridge between a single CPU native memory port (valid/instr/addr/wdata/wstrb, rdata/ready) and one instruction bus plus N_DBUS data buses in IOb native format. It registers each request and routes it by the instr flag and by address MSBs. It supports boot-dependent external-memory address remapping and a watchdog that terminates hung accesses with an error word. It sits between the CPU core wrapper and the system interconnect.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
N_DBUS, 2, number of data-bus channels (>=1; power of 2)
SEL_W, $clog2(N_DBUS) (min 1), data channel select width (derived)
USE_EXTMEM, 0, 1 enables boot-dependent MSB remap
TIMEOUT_W, 8, watchdog counter width; timeout = 2**TIMEOUT_W-1 cycles
ERR_RDATA, 32'hDEADBEEF, rdata returned on timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
boot  in  1  1 = boot phase (no remap)
cpu_valid  in  1  CPU request valid, held until cpu_ready
cpu_instr  in  1  1 = instruction fetch
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  DATA_W  write data
cpu_wstrb  in  DATA_W/8  write strobes, 0 = read
cpu_rdata  out  DATA_W  registered read data
cpu_ready  out  1  one-cycle completion pulse
ibus_valid  out  1  instruction bus valid
ibus_addr  out  ADDR_W  instruction bus address
ibus_rdata  in  DATA_W  instruction read data
ibus_ready  in  1  instruction ready
dbus_valid  out  N_DBUS  per-channel valid
dbus_addr  out  N_DBUS*ADDR_W  per-channel address (all equal)
dbus_wdata  out  N_DBUS*DATA_W  per-channel write data
dbus_wstrb  out  N_DBUS*DATA_W/8  per-channel strobes
dbus_rdata  in  N_DBUS*DATA_W  per-channel read data
dbus_ready  in  N_DBUS  per-channel ready
err_clr  in  1  clears timeout_err
timeout_err  out  1  sticky timeout flag
busy  out  1  FSM not IDLE

Behaviour:
- Reset (async): FSM=IDLE; all valids 0; cpu_ready 0; cpu_rdata 0; timeout_err 0; latched address/data/strobes 0; counter 0.
- FSM IDLE -> REQ -> RESP -> IDLE. One transaction in flight.
- IDLE: when cpu_valid=1, latch instr, remapped addr, wdata, wstrb and target at the clk edge; go to REQ. Capture happens only in IDLE.
- Remap (USE_EXTMEM=1): instr MSB = ~boot. Data MSB = (addr[ADDR_W-1] ^ ~boot) & ~addr[ADDR_W-2]. Other bits pass through. With USE_EXTMEM=0, addr passes through unchanged. boot is sampled only at capture; a boot change mid-transaction has no effect.
- Target: instr goes to ibus. Data goes to channel addr_remapped[ADDR_W-1 -: SEL_W]. For N_DBUS=1, always channel 0.
- REQ: valid of the target = 1 & ~target_ready (combinational mask, so there is no extra valid cycle). Non-target valids stay 0. Address/wdata/wstrb are driven to all dbus channels from the latch; ibus is read-only, so wstrb is ignored for instr.
- On target ready=1: latch target rdata (ibus_rdata, or zero for writes is not required: latch whatever is presented). Go to RESP.
- RESP: cpu_ready=1 for exactly one cycle, then IDLE. cpu_valid still high during this cycle is not recaptured.
- Latency: with zero-wait slaves, cpu_valid at cycle 0 gives slave valid in cycle 1, cpu_ready in cycle 2. Minimum 3 cycles per access.
- Watchdog: the counter clears on entry to REQ and increments each REQ cycle. When it hits all-ones with no ready: drop valid, cpu_rdata=ERR_RDATA, set timeout_err, go to RESP. A ready arriving in the same cycle as expiry wins, and no error is raised.
- timeout_err: err_clr clears it. A simultaneous set and clear results in set.
- busy = (state != IDLE).
- A ready from a non-target channel is ignored.

Decomposition:
- Package/header iob_cpu_bridge_pkg: FSM state encoding (IDLE=0, REQ=1, RESP=2), ERR_RDATA default, field-width macros (WSTRB_W = DATA_W/8).
- One sub-module: iob_bus_watchdog (counter, clear, expiry pulse), reusable elsewhere.

Test Plan:
- Fetch: cpu_valid=1, instr=1, addr=0x100, ibus_ready after 2 cycles with rdata 0x00000013 -> ibus_valid high 2 cycles (cycles 1-2), cpu_ready in cycle 4, cpu_rdata=0x00000013; dbus_valid=0 throughout.
- Data route, N_DBUS=2, USE_EXTMEM=0: write addr=0x80000010, wdata=0xA5A5A5A5, wstrb=0xF -> only dbus_valid[1] asserted, dbus_addr=0x80000010, dbus_wstrb=0xF; one cpu_ready pulse.
- Remap, USE_EXTMEM=1, boot=0: fetch addr=0x00000040 -> ibus_addr=0x80000040. Data read 0x00000020 -> channel 1, addr 0x80000020. Data read 0x40000000 -> channel 0, MSB 0.
- Timeout, TIMEOUT_W=4: target never ready -> valid drops after 15 REQ cycles, cpu_rdata=0xDEADBEEF, cpu_ready pulse, timeout_err=1 until err_clr; ready at the expiry cycle -> no error.
- Reset mid-op: assert rst during REQ -> immediately all valids 0, busy 0, cpu_ready 0. After release, a new request completes normally.
- Back-to-back: cpu_valid reasserted the cycle after cpu_ready -> second access captured in that IDLE cycle, with no duplicate slave valid for the first.

Source files
------------

// File: rtl/iob_cpu_bridge_pkg.sv
// Shared definitions for the CPU-to-IOb bus bridge: FSM state encoding,
// default error read word and strobe-width helper.
package iob_cpu_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } bridge_state_t;

   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

   function automatic int wstrb_w(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/iob_bus_watchdog.sv
// Bus-access watchdog: counts cycles while enabled and flags expiry when the
// counter reaches all-ones; clr restarts the count for a new access.
module iob_bus_watchdog #(
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expired = en & (cnt_q == '1);

   // Holds at all-ones after expiry so the flag stays stable until cleared.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !expired) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/iob_cpu_bus_bridge.sv
// Bridge from one CPU native memory port to an instruction bus and N_DBUS
// data buses; one registered transaction in flight, with watchdog timeout.
module iob_cpu_bus_bridge
   import iob_cpu_bridge_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                N_DBUS     = 2,
   parameter int                SEL_W      = (N_DBUS > 1) ? $clog2(N_DBUS) : 1,
   parameter int                USE_EXTMEM = 0,
   parameter int                TIMEOUT_W  = 8,
   parameter logic [DATA_W-1:0] ERR_RDATA  = DATA_W'(ERR_RDATA_DEFAULT)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       boot,
   input  logic                       cpu_valid,
   input  logic                       cpu_instr,
   input  logic [ADDR_W-1:0]          cpu_addr,
   input  logic [DATA_W-1:0]          cpu_wdata,
   input  logic [DATA_W/8-1:0]        cpu_wstrb,
   output logic [DATA_W-1:0]          cpu_rdata,
   output logic                       cpu_ready,
   output logic                       ibus_valid,
   output logic [ADDR_W-1:0]          ibus_addr,
   input  logic [DATA_W-1:0]          ibus_rdata,
   input  logic                       ibus_ready,
   output logic [N_DBUS-1:0]          dbus_valid,
   output logic [N_DBUS*ADDR_W-1:0]   dbus_addr,
   output logic [N_DBUS*DATA_W-1:0]   dbus_wdata,
   output logic [N_DBUS*DATA_W/8-1:0] dbus_wstrb,
   input  logic [N_DBUS*DATA_W-1:0]   dbus_rdata,
   input  logic [N_DBUS-1:0]          dbus_ready,
   input  logic                       err_clr,
   output logic                       timeout_err,
   output logic                       busy
);

   localparam int WSTRB_W = wstrb_w(DATA_W);

   bridge_state_t      state_q, state_d;
   logic               instr_q, instr_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [WSTRB_W-1:0] wstrb_q, wstrb_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic               err_q, err_d;

   logic [ADDR_W-1:0]  addr_remap;
   logic [SEL_W-1:0]   sel_new;
   logic [DATA_W-1:0]  ch_rdata [N_DBUS];
   logic               in_req;
   logic               tgt_ready;
   logic [DATA_W-1:0]  tgt_rdata;
   logic               expired;
   logic               wd_clr;
   logic               req_live;

   // External-memory remap flips the MSB only outside the boot phase.
   always_comb begin
      addr_remap = cpu_addr;
      if (USE_EXTMEM != 0) begin
         if (cpu_instr) begin
            addr_remap[ADDR_W-1] = ~boot;
         end else begin
            addr_remap[ADDR_W-1] = (cpu_addr[ADDR_W-1] ^ ~boot) & ~cpu_addr[ADDR_W-2];
         end
      end
   end

   generate
      if (N_DBUS > 1) begin : g_sel
         assign sel_new = addr_remap[ADDR_W-1 -: SEL_W];
      end else begin : g_sel_single
         assign sel_new = '0;
      end
   endgenerate

   assign in_req    = (state_q == ST_REQ);
   assign tgt_ready = instr_q ? ibus_ready : dbus_ready[sel_q];
   assign tgt_rdata = instr_q ? ibus_rdata : ch_rdata[sel_q];
   assign req_live  = in_req & ~tgt_ready & ~expired;

   assign ibus_valid  = req_live & instr_q;
   assign ibus_addr   = addr_q;
   assign cpu_ready   = (state_q == ST_RESP);
   assign cpu_rdata   = rdata_q;
   assign timeout_err = err_q;
   assign busy        = (state_q != ST_IDLE);

   genvar gi;
   generate
      for (gi = 0; gi < N_DBUS; gi++) begin : g_ch
         assign ch_rdata[gi]                      = dbus_rdata[gi*DATA_W +: DATA_W];
         assign dbus_valid[gi]                    = req_live & ~instr_q & (sel_q == SEL_W'(gi));
         assign dbus_addr[gi*ADDR_W +: ADDR_W]    = addr_q;
         assign dbus_wdata[gi*DATA_W +: DATA_W]   = wdata_q;
         assign dbus_wstrb[gi*WSTRB_W +: WSTRB_W] = wstrb_q;
      end
   endgenerate

   iob_bus_watchdog #(
      .CNT_W (TIMEOUT_W)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (wd_clr),
      .en      (in_req),
      .expired (expired)
   );

   // A ready in the expiry cycle takes priority; a timeout set beats err_clr.
   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      sel_d   = sel_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      wd_clr  = 1'b0;
      if (err_clr) begin
         err_d = 1'b0;
      end
      case (state_q)
         ST_IDLE: begin
            if (cpu_valid) begin
               instr_d = cpu_instr;
               addr_d  = addr_remap;
               wdata_d = cpu_wdata;
               wstrb_d = cpu_wstrb;
               sel_d   = sel_new;
               wd_clr  = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (tgt_ready) begin
               rdata_d = tgt_rdata;
               state_d = ST_RESP;
            end else if (expired) begin
               rdata_d = ERR_RDATA;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         instr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         sel_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         sel_q   <= sel_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_iob_cpu_bus_bridge.sv
// Self-checking bench: two bridges (pass-through and remapping) driven with
// directed and random accesses against a cycle-level reference model.
module tb_iob_cpu_bus_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        boot;
   logic        cpu_valid;
   logic        cpu_instr;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_wstrb;
   logic [31:0] ibus_rdata;
   logic        ibus_ready;
   logic [63:0] dbus_rdata;
   logic [1:0]  dbus_ready;
   logic        err_clr;

   logic [31:0] a_cpu_rdata, b_cpu_rdata;
   logic        a_cpu_ready, b_cpu_ready;
   logic        a_ibus_valid, b_ibus_valid;
   logic [31:0] a_ibus_addr, b_ibus_addr;
   logic [1:0]  a_dbus_valid, b_dbus_valid;
   logic [63:0] a_dbus_addr, b_dbus_addr;
   logic [63:0] a_dbus_wdata, b_dbus_wdata;
   logic [7:0]  a_dbus_wstrb, b_dbus_wstrb;
   logic        a_timeout_err, b_timeout_err;
   logic        a_busy, b_busy;

   int   checks = 0;
   int   errors = 0;
   logic err_model = 1'b0;

   always #5 clk = ~clk;

   iob_cpu_bus_bridge #(
      .ADDR_W(32), .DATA_W(32), .N_DBUS(2), .USE_EXTMEM(0), .TIMEOUT_W(4)
   ) dut_a (
      .clk(clk), .rst(rst), .boot(boot),
      .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
      .cpu_rdata(a_cpu_rdata), .cpu_ready(a_cpu_ready),
      .ibus_valid(a_ibus_valid), .ibus_addr(a_ibus_addr),
      .ibus_rdata(ibus_rdata), .ibus_ready(ibus_ready),
      .dbus_valid(a_dbus_valid), .dbus_addr(a_dbus_addr),
      .dbus_wdata(a_dbus_wdata), .dbus_wstrb(a_dbus_wstrb),
      .dbus_rdata(dbus_rdata), .dbus_ready(dbus_ready),
      .err_clr(err_clr), .timeout_err(a_timeout_err), .busy(a_busy)
   );

   iob_cpu_bus_bridge #(
      .ADDR_W(32), .DATA_W(32), .N_DBUS(2), .USE_EXTMEM(1), .TIMEOUT_W(4)
   ) dut_b (
      .clk(clk), .rst(rst), .boot(boot),
      .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
      .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready),
      .ibus_valid(b_ibus_valid), .ibus_addr(b_ibus_addr),
      .ibus_rdata(ibus_rdata), .ibus_ready(ibus_ready),
      .dbus_valid(b_dbus_valid), .dbus_addr(b_dbus_addr),
      .dbus_wdata(b_dbus_wdata), .dbus_wstrb(b_dbus_wstrb),
      .dbus_rdata(dbus_rdata), .dbus_ready(dbus_ready),
      .err_clr(err_clr), .timeout_err(b_timeout_err), .busy(b_busy)
   );

   // Address seen on the buses: MSB rewritten only when remapping is enabled.
   function automatic logic [31:0] exp_addr(input bit ext, input logic instr,
                                            input logic bt, input logic [31:0] a);
      logic msb;
      if (!ext) return a;
      if (instr) msb = (bt == 1'b0);
      else       msb = (a[31] == bt) && (a[30] == 1'b0);
      return {msb, a[30:0]};
   endfunction

   // One-hot {ibus, dbus1, dbus0}
   function automatic logic [2:0] tgt_vec(input logic instr, input logic [31:0] a);
      if (instr) return 3'b100;
      return a[31] ? 3'b010 : 3'b001;
   endfunction

   function automatic logic [31:0] pick(input logic [2:0] v, input logic [31:0] ri,
                                        input logic [31:0] r0, input logic [31:0] r1);
      if (v[2]) return ri;
      return v[1] ? r1 : r0;
   endfunction

   // delay >= 16 means the target never answers; all_rdy raises every ready
   // together, otherwise only the target answers while the others chatter.
   task automatic txn(input string nm, input logic instr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wstrb, input logic bt,
                      input int delay, input bit all_rdy, input int clr_at,
                      input bit hold, input bit chk_b);
      logic [31:0] ea, eb, rd_i, rd0, rd1, exp_rd_a, exp_rd_b;
      logic [2:0]  va, vb;
      logic [4:0]  obs, expv;
      logic        rdy_now, noise;
      bit          to;
      int          resp;
      ea   = exp_addr(1'b0, instr, bt, addr);
      eb   = exp_addr(1'b1, instr, bt, addr);
      va   = tgt_vec(instr, ea);
      vb   = tgt_vec(instr, eb);
      to   = (delay >= 16);
      resp = to ? 17 : delay + 2;
      rd_i = $urandom; rd0 = $urandom; rd1 = $urandom;
      exp_rd_a = to ? 32'hDEADBEEF : pick(va, rd_i, rd0, rd1);
      exp_rd_b = to ? 32'hDEADBEEF : pick(vb, rd_i, rd0, rd1);
      ibus_rdata = rd_i;
      dbus_rdata = {rd1, rd0};
      cpu_valid = 1'b1; cpu_instr = instr; cpu_addr = addr;
      cpu_wdata = wdata; cpu_wstrb = wstrb; boot = bt;
      ibus_ready = 1'b0; dbus_ready = 2'b00; err_clr = 1'b0;
      #1;
      obs = {a_ibus_valid, a_dbus_valid, a_cpu_ready, a_busy};
      checks++;
      if (obs !== 5'b0) begin
         errors++;
         $display("FAIL %s idle_outputs: got %b expected %b", nm, obs, 5'b0);
      end
      for (int c = 1; c <= resp; c++) begin
         @(posedge clk);
         #1;
         rdy_now = !to && (c == delay + 1);
         noise   = (c < resp);
         if (all_rdy) begin
            ibus_ready = rdy_now;
            dbus_ready = {rdy_now, rdy_now};
         end else begin
            ibus_ready    = va[2] ? rdy_now : noise;
            dbus_ready[1] = va[1] ? rdy_now : noise;
            dbus_ready[0] = va[0] ? rdy_now : noise;
         end
         err_clr = (c == clr_at);
         @(negedge clk);
         obs  = {a_ibus_valid, a_dbus_valid, a_cpu_ready, a_busy};
         expv = {(c <= resp - 2) ? va : 3'b000, (c == resp), 1'b1};
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL %s cycle%0d_handshake: got %b expected %b", nm, c, obs, expv);
         end
         checks++;
         if (a_timeout_err !== err_model) begin
            errors++;
            $display("FAIL %s cycle%0d_timeout_err: got %b expected %b", nm, c, a_timeout_err, err_model);
         end
         if (c == 1) begin
            checks++;
            if ({a_ibus_addr, a_dbus_addr, a_dbus_wdata, a_dbus_wstrb} !==
                {ea, ea, ea, wdata, wdata, wstrb, wstrb}) begin
               errors++;
               $display("FAIL %s latched_fields: got addr %h/%h wdata %h wstrb %h expected addr %h wdata %h wstrb %h",
                        nm, a_ibus_addr, a_dbus_addr, a_dbus_wdata, a_dbus_wstrb, ea, wdata, wstrb);
            end
            if (chk_b) begin
               checks++;
               if ({b_ibus_addr, b_dbus_addr} !== {eb, eb, eb}) begin
                  errors++;
                  $display("FAIL %s remap_addr: got %h/%h expected %h", nm, b_ibus_addr, b_dbus_addr, eb);
               end
               if (delay > 0) begin
                  checks++;
                  if ({b_ibus_valid, b_dbus_valid} !== vb) begin
                     errors++;
                     $display("FAIL %s remap_route: got %b expected %b", nm, {b_ibus_valid, b_dbus_valid}, vb);
                  end
               end
            end
         end
         if (c == resp) begin
            checks++;
            if (a_cpu_rdata !== exp_rd_a) begin
               errors++;
               $display("FAIL %s rdata: got %h expected %h", nm, a_cpu_rdata, exp_rd_a);
            end
            if (chk_b) begin
               checks++;
               if ({b_cpu_ready, b_busy, b_cpu_rdata} !== {2'b11, exp_rd_b}) begin
                  errors++;
                  $display("FAIL %s remap_resp: got %b%b %h expected 11 %h",
                           nm, b_cpu_ready, b_busy, b_cpu_rdata, exp_rd_b);
               end
            end
         end
         // Flag state after the edge that closes this cycle.
         if (to && c == 16)    err_model = 1'b1;
         else if (c == clr_at) err_model = 1'b0;
      end
      if (!hold) cpu_valid = 1'b0;
      ibus_ready = 1'b0; dbus_ready = 2'b00; err_clr = 1'b0;
      @(negedge clk);
      $display("txn %s instr=%0b addr=%h boot=%0b delay=%0d done", nm, instr, addr, bt, delay);
   endtask

   task automatic do_reset();
      rst = 1'b1; cpu_valid = 1'b0; cpu_instr = 1'b0; cpu_addr = '0;
      cpu_wdata = '0; cpu_wstrb = '0; boot = 1'b1; ibus_rdata = '0;
      ibus_ready = 1'b0; dbus_rdata = '0; dbus_ready = 2'b00; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      err_model = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({a_ibus_valid, a_dbus_valid, a_cpu_ready, a_busy, a_timeout_err, a_cpu_rdata} !== 38'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b%b%b%b%b %h expected all zero",
                  a_ibus_valid, a_dbus_valid, a_cpu_ready, a_busy, a_timeout_err, a_cpu_rdata);
      end
      checks++;
      if ({a_ibus_addr, a_dbus_addr, a_dbus_wdata, a_dbus_wstrb, b_dbus_valid, b_busy} !== 203'b0) begin
         errors++;
         $display("FAIL reset_latches: got addr %h wdata %h wstrb %h expected zero",
                  a_dbus_addr, a_dbus_wdata, a_dbus_wstrb);
      end
      $display("txn reset done");
   endtask

   task automatic test_fetch();
      txn("fetch", 1'b1, 32'h0000_0100, 32'h0, 4'h0, 1'b1, 2, 1'b0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_data_route();
      txn("write_ch1", 1'b0, 32'h8000_0010, 32'hA5A5_A5A5, 4'hF, 1'b1, 1, 1'b0, -1, 1'b0, 1'b0);
      txn("read_ch0", 1'b0, 32'h0000_0044, 32'h0, 4'h0, 1'b1, 3, 1'b0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_remap();
      txn("remap_fetch", 1'b1, 32'h0000_0040, 32'h0, 4'h0, 1'b0, 1, 1'b1, -1, 1'b0, 1'b1);
      txn("remap_rd20", 1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0, 1, 1'b1, -1, 1'b0, 1'b1);
      txn("remap_rd40m", 1'b0, 32'h4000_0000, 32'h0, 4'h0, 1'b0, 2, 1'b1, -1, 1'b0, 1'b1);
      txn("boot_fetch", 1'b1, 32'h8000_0040, 32'h0, 4'h0, 1'b1, 1, 1'b1, -1, 1'b0, 1'b1);
   endtask

   task automatic test_timeout();
      txn("timeout", 1'b0, 32'h0000_0008, 32'h0, 4'h0, 1'b1, 99, 1'b0, -1, 1'b0, 1'b0);
      txn("err_sticky", 1'b1, 32'h0000_0200, 32'h0, 4'h0, 1'b1, 0, 1'b0, -1, 1'b0, 1'b0);
      txn("err_clear", 1'b1, 32'h0000_0204, 32'h0, 4'h0, 1'b1, 2, 1'b0, 1, 1'b0, 1'b0);
      txn("set_vs_clr", 1'b0, 32'h8000_0000, 32'h0, 4'h0, 1'b1, 99, 1'b0, 16, 1'b0, 1'b0);
      txn("err_clear2", 1'b0, 32'h0000_0000, 32'h0, 4'h0, 1'b1, 0, 1'b0, 1, 1'b0, 1'b0);
      txn("ready_at_expiry", 1'b1, 32'h0000_0300, 32'h0, 4'h0, 1'b1, 15, 1'b0, -1, 1'b0, 1'b0);
      txn("ready_before_expiry", 1'b0, 32'h8000_0300, 32'h1234_5678, 4'h3, 1'b1, 14, 1'b0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midop();
      cpu_valid = 1'b1; cpu_instr = 1'b0; cpu_addr = 32'h0000_0008;
      cpu_wdata = 32'h0; cpu_wstrb = 4'h0; boot = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (a_dbus_valid !== 2'b01) begin
         errors++;
         $display("FAIL midop_req_valid: got %b expected 01", a_dbus_valid);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({a_ibus_valid, a_dbus_valid, a_cpu_ready, a_busy} !== 5'b0) begin
         errors++;
         $display("FAIL midop_reset: got %b expected 00000",
                  {a_ibus_valid, a_dbus_valid, a_cpu_ready, a_busy});
      end
      @(negedge clk);
      rst = 1'b0; cpu_valid = 1'b0; err_model = 1'b0;
      @(negedge clk);
      txn("after_reset", 1'b0, 32'h8000_0008, 32'hCAFE_F00D, 4'hC, 1'b1, 1, 1'b0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      txn("b2b_first", 1'b0, 32'h0000_0010, 32'h1111_1111, 4'hF, 1'b1, 1, 1'b0, -1, 1'b1, 1'b0);
      txn("b2b_second", 1'b0, 32'h8000_0014, 32'h2222_2222, 4'h1, 1'b1, 1, 1'b0, -1, 1'b1, 1'b0);
      txn("b2b_third", 1'b1, 32'h0000_0018, 32'h0, 4'h0, 1'b1, 0, 1'b0, -1, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic        instr;
      logic [3:0]  ws;
      bit          hold;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         instr = 1'($urandom_range(0, 1));
         ws    = instr ? 4'h0 : 4'($urandom_range(0, 15));
         hold  = (i != 39) && ($urandom_range(0, 1) == 1);
         txn($sformatf("rand%0d", i), instr, {$urandom} & 32'hFFFF_FFFC, $urandom, ws,
             1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'b1, -1, hold, 1'b1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_remap();
      test_fetch();
      test_data_route();
      test_timeout();
      test_reset_midop();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
